// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage: state encodings,
// instruction field positions and the default boot address.
package fetch_stage_pkg;

    localparam logic [1:0] FETCH_ST_BOOT  = 2'd0;
    localparam logic [1:0] FETCH_ST_FETCH = 2'd1;
    localparam logic [1:0] FETCH_ST_SKID  = 2'd2;
    localparam logic [1:0] FETCH_ST_DRAIN = 2'd3;

    localparam logic [31:0] INS_NOP = 32'h0000_0000;

    localparam int INS_OP_MSB = 31;
    localparam int INS_OP_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction word and its address, used
// when a fetch completes while the decoder is stalled.
module fetch_skid
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] load_word,
    input  logic [XLEN-1:0] load_pc,
    output logic            full,
    output logic [XLEN-1:0] word,
    output logic [XLEN-1:0] pc
);

    // Flush wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            word <= XLEN'(INS_NOP);
            pc   <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            word <= load_word;
            pc   <= load_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, runs a single-outstanding req/ack
// read to instruction memory and registers one instruction for the decoder.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins_word,
    output logic [XLEN-1:0] ins_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [5:0]      ins_op,
    output logic [5:0]      func_code
);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redirect_target;
    logic            slot_free;
    logic            redirect_live;

    logic            skid_load;
    logic            skid_unload;
    logic            skid_flush;
    logic            skid_full;
    logic [XLEN-1:0] skid_word;
    logic [XLEN-1:0] skid_pc;

    // Masking instead of slicing keeps every redirect_pc bit in use.
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign pc_seq          = pc + XLEN'(PC_STEP);
    assign slot_free       = !ins_valid || !stall;
    assign redirect_live   = redirect && (state != FETCH_ST_BOOT);

    assign imem_req  = (state == FETCH_ST_FETCH) || (state == FETCH_ST_DRAIN);
    assign imem_addr = (state == FETCH_ST_DRAIN) ? drain_addr : pc;

    assign ins_op    = ins_word[INS_OP_MSB:INS_OP_LSB];
    assign func_code = ins_word[FUNC_MSB:FUNC_LSB];
    assign pc_plus4  = ins_pc + XLEN'(PC_STEP);

    assign skid_load   = (state == FETCH_ST_FETCH) && !redirect && imem_ack && !slot_free;
    assign skid_unload = (state == FETCH_ST_SKID) && !redirect && slot_free;
    assign skid_flush  = redirect_live;

    fetch_skid #(
        .XLEN(XLEN)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .load_word (imem_rdata),
        .load_pc   (pc),
        .full      (skid_full),
        .word      (skid_word),
        .pc        (skid_pc)
    );

    // drain_addr freezes the address of a request that a redirect orphaned,
    // so the bus stays stable until the memory finally acknowledges it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH_ST_BOOT;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            case (state)
                FETCH_ST_BOOT: begin
                    state <= FETCH_ST_FETCH;
                    if (redirect) begin
                        pc <= redirect_target;
                    end
                end
                FETCH_ST_FETCH: begin
                    if (redirect) begin
                        pc <= redirect_target;
                        if (!imem_ack) begin
                            state      <= FETCH_ST_DRAIN;
                            drain_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_seq;
                        if (!slot_free) begin
                            state <= FETCH_ST_SKID;
                        end
                    end
                end
                FETCH_ST_SKID: begin
                    if (redirect) begin
                        pc    <= redirect_target;
                        state <= FETCH_ST_FETCH;
                    end else if (slot_free && skid_full) begin
                        state <= FETCH_ST_FETCH;
                    end
                end
                FETCH_ST_DRAIN: begin
                    if (redirect) begin
                        pc <= redirect_target;
                    end
                    if (imem_ack) begin
                        state <= FETCH_ST_FETCH;
                    end
                end
                default: begin
                    state <= FETCH_ST_BOOT;
                end
            endcase
        end
    end

    // Output register; a redirect clears it even when a consume coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_valid <= 1'b0;
            ins_word  <= XLEN'(INS_NOP);
            ins_pc    <= '0;
        end else if (redirect_live) begin
            ins_valid <= 1'b0;
        end else if ((state == FETCH_ST_FETCH) && imem_ack && slot_free) begin
            ins_valid <= 1'b1;
            ins_word  <= imem_rdata;
            ins_pc    <= pc;
        end else if ((state == FETCH_ST_SKID) && slot_free && skid_full) begin
            ins_valid <= 1'b1;
            ins_word  <= skid_word;
            ins_pc    <= skid_pc;
        end else if (ins_valid && !stall) begin
            ins_valid <= 1'b0;
        end
    end

endmodule
